// File: rtl/ng_mem_resp_pkg.sv
// Shared encodings and address-class boundaries for the memory responder and the address decoder.
package ng_mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_REG,
        CLS_ERS,
        CLS_FIX
    } cls_t;

    localparam logic [13:0] REG_LIMIT = 14'o20;
    localparam logic [13:0] FIX_BASE  = 14'o2000;

    // Odd parity: the bit that makes the total count of ones odd.
    function automatic logic odd_parity(input logic [15:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ng_mem_class.sv
// Combinational address classifier: maps a bank-resolved address to its class and wait count.
module ng_mem_class
    import ng_mem_resp_pkg::*;
#(
    parameter int unsigned ERS_WAIT = 1,
    parameter int unsigned FIX_WAIT = 2
) (
    input  logic [13:0] addr,
    output cls_t        cls,
    output logic [3:0]  wait_cnt
);

    always_comb begin
        cls      = CLS_FIX;
        wait_cnt = 4'(FIX_WAIT);
        if (addr < REG_LIMIT) begin
            cls      = CLS_REG;
            wait_cnt = '0;
        end else if (addr < FIX_BASE) begin
            cls      = CLS_ERS;
            wait_cnt = 4'(ERS_WAIT);
        end
    end

endmodule

// File: rtl/ng_mem_resp.sv
// Wait-stated memory responder for the address path; optional parity via NG_MEM_RESP_PARITY_EN.
module ng_mem_resp
    import ng_mem_resp_pkg::*;
#(
    parameter int unsigned ERS_WAIT = 1,
    parameter int unsigned FIX_WAIT = 2
) (
    input  logic        CLK2,
    input  logic        RESET,
    input  logic [13:0] ADDRESS,
    input  logic [15:0] WRITE_BUS,
    input  logic        RD_REQ,
    input  logic        WR_REQ,
    output logic [15:0] READ_BUS,
    output logic        ACK,
    output logic        BUSY,
    output logic [13:0] MEM_ADDR,
    output logic        MEM_OE,
    output logic        MEM_WE,
    output logic [16:0] MEM_DOUT,
    input  logic [16:0] MEM_DIN,
    output logic        PAR_ALARM
);

    state_t     state;
    logic [3:0] cnt;
    logic       op_wr;
    cls_t       in_cls;
    logic [3:0] in_wait;
    logic       wr_par;
    logic       rd_capture;

    ng_mem_class #(
        .ERS_WAIT(ERS_WAIT),
        .FIX_WAIT(FIX_WAIT)
    ) u_class (
        .addr     (ADDRESS),
        .cls      (in_cls),
        .wait_cnt (in_wait)
    );

    assign rd_capture = (state == ST_ACCESS) && (cnt == '0) && !op_wr;

    // Strobes and ACK are registered so they change exactly on state transitions.
    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            READ_BUS <= '0;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
            MEM_ADDR <= '0;
            MEM_OE   <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_DOUT <= '0;
        end else begin
            ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (RD_REQ || WR_REQ) begin
                        op_wr <= WR_REQ;
                        BUSY  <= 1'b1;
                        if (in_cls == CLS_REG) begin
                            state <= ST_DONE;
                            ACK   <= 1'b1;
                            if (!WR_REQ)
                                READ_BUS <= '0;
                        end else begin
                            state    <= ST_ACCESS;
                            cnt      <= in_wait;
                            MEM_ADDR <= ADDRESS;
                            MEM_OE   <= !WR_REQ;
                            MEM_WE   <= WR_REQ && (in_cls == CLS_ERS);
                            if (WR_REQ)
                                MEM_DOUT <= {wr_par, WRITE_BUS};
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state  <= ST_DONE;
                        ACK    <= 1'b1;
                        MEM_OE <= 1'b0;
                        MEM_WE <= 1'b0;
                        if (!op_wr)
                            READ_BUS <= MEM_DIN[15:0];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    BUSY   <= 1'b0;
                    MEM_OE <= 1'b0;
                    MEM_WE <= 1'b0;
                end
            endcase
        end
    end

`ifdef NG_MEM_RESP_PARITY_EN
    assign wr_par = odd_parity(WRITE_BUS);

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET)
            PAR_ALARM <= 1'b0;
        else if (rd_capture && !(^MEM_DIN))
            PAR_ALARM <= 1'b1;
    end
`else
    logic unused_par;
    assign unused_par = MEM_DIN[16] ^ rd_capture;
    assign wr_par     = 1'b0;
    assign PAR_ALARM  = 1'b0;
`endif

endmodule

// File: tb/tb_ng_mem_resp.sv
// Randomized self-checking bench for ng_mem_resp against a transaction-level reference model.
module tb_ng_mem_resp;

    localparam int unsigned ERS_W = 1;
    localparam int unsigned FIX_W = 2;
`ifdef NG_MEM_RESP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        CLK2 = 1'b0;
    logic        RESET;
    logic [13:0] ADDRESS;
    logic [15:0] WRITE_BUS;
    logic        RD_REQ;
    logic        WR_REQ;
    logic [15:0] READ_BUS;
    logic        ACK;
    logic        BUSY;
    logic [13:0] MEM_ADDR;
    logic        MEM_OE;
    logic        MEM_WE;
    logic [16:0] MEM_DOUT;
    logic [16:0] MEM_DIN;
    logic        PAR_ALARM;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // External memory contents and the bench's own expectation of them.
    logic [16:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    bit          bad_par [0:16383];
    logic [15:0] exp_rb;
    logic        exp_alarm;

    always #5 CLK2 = ~CLK2;

    ng_mem_resp #(
        .ERS_WAIT(ERS_W),
        .FIX_WAIT(FIX_W)
    ) dut (
        .CLK2      (CLK2),
        .RESET     (RESET),
        .ADDRESS   (ADDRESS),
        .WRITE_BUS (WRITE_BUS),
        .RD_REQ    (RD_REQ),
        .WR_REQ    (WR_REQ),
        .READ_BUS  (READ_BUS),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_OE    (MEM_OE),
        .MEM_WE    (MEM_WE),
        .MEM_DOUT  (MEM_DOUT),
        .MEM_DIN   (MEM_DIN),
        .PAR_ALARM (PAR_ALARM)
    );

    assign MEM_DIN = mem[MEM_ADDR];

    always @(posedge CLK2) begin
        if (MEM_WE)
            mem[MEM_ADDR] = MEM_DOUT;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(negedge CLK2);
        @(negedge CLK2);
        RESET     = 1'b0;
        exp_rb    = '0;
        exp_alarm = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_txn(input logic rd, input logic wr, input logic [13:0] a,
                          input logic [15:0] d, input logic poke_busy);
        bit          is_reg, is_ers, done;
        int unsigned w, exp_lat, exp_oe, exp_we;
        int unsigned oe_n, we_n, ack_n, ack_at;
        is_reg  = (a < 16);
        is_ers  = !is_reg && (a <= 1023);
        w       = is_reg ? 0 : (is_ers ? ERS_W : FIX_W);
        exp_lat = is_reg ? 1 : w + 2;
        exp_oe  = (!wr && !is_reg) ? w + 1 : 0;
        exp_we  = (wr && is_ers) ? w + 1 : 0;
        oe_n = 0; we_n = 0; ack_n = 0; ack_at = 0; done = 0;

        if (wr && is_ers) begin
            ref_mem[a] = d;
            bad_par[a] = !PAR_EN;
        end
        if (!wr) begin
            exp_rb = is_reg ? 16'h0000 : ref_mem[a];
            if (!is_reg && PAR_EN && bad_par[a])
                exp_alarm = 1'b1;
        end

        ADDRESS = a; WRITE_BUS = d; RD_REQ = rd; WR_REQ = wr;
        @(posedge CLK2);
        #1;
        RD_REQ = 1'b0; WR_REQ = 1'b0;
        ADDRESS = 14'($urandom); WRITE_BUS = 16'($urandom);

        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge CLK2);
            if (k == 2)
                RD_REQ = 1'b0;
            if (k == 1)
                check("busy_during", {31'b0, BUSY}, 32'd1);
            if (MEM_OE) begin
                oe_n++;
                check("oe_addr", {18'b0, MEM_ADDR}, {18'b0, a});
            end
            if (MEM_WE) begin
                we_n++;
                check("we_addr", {18'b0, MEM_ADDR}, {18'b0, a});
                check("we_data", {15'b0, MEM_DOUT}, {15'b0, (PAR_EN ? ~(^d) : 1'b0), d});
            end
            if (ack_at != 0 && k > ack_at) begin
                check("busy_after", {31'b0, BUSY}, 32'd0);
                done = 1;
            end
            if (ACK) begin
                ack_n++;
                if (ack_at == 0) begin
                    ack_at = k;
                    check("read_bus", {16'b0, READ_BUS}, {16'b0, exp_rb});
                    check("par_alarm", {31'b0, PAR_ALARM}, {31'b0, exp_alarm});
                end
            end
            if (poke_busy && k == 1)
                RD_REQ = 1'b1;
        end
        RD_REQ = 1'b0;
        check("ack_latency", ack_at, exp_lat);
        check("ack_count", ack_n, 32'd1);
        check("oe_cycles", oe_n, exp_oe);
        check("we_cycles", we_n, exp_we);
    endtask

    initial begin
        int unsigned acks;
        logic [15:0] d;
        RESET = 1'b1; ADDRESS = '0; WRITE_BUS = '0; RD_REQ = 1'b0; WR_REQ = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            d          = 16'($urandom);
            mem[i]     = {~(^d), d};
            ref_mem[i] = d;
            bad_par[i] = 1'b0;
        end
        exp_rb = '0; exp_alarm = 1'b0;
        @(negedge CLK2);
        @(negedge CLK2);
        RESET = 1'b0;
        @(negedge CLK2);

        check("rst_read_bus", {16'b0, READ_BUS}, 32'd0);
        check("rst_strobes", {28'b0, ACK, BUSY, MEM_OE, MEM_WE}, 32'd0);
        check("rst_mem_addr", {18'b0, MEM_ADDR}, 32'd0);
        check("rst_mem_dout", {15'b0, MEM_DOUT}, 32'd0);
        check("rst_par_alarm", {31'b0, PAR_ALARM}, 32'd0);

        // Directed cases.
        do_txn(1'b0, 1'b1, 14'o1234, 16'h5A5A, 1'b0);
        do_txn(1'b1, 1'b0, 14'o1234, 16'h0000, 1'b0);
        do_txn(1'b0, 1'b1, 14'o4000, 16'hBEEF, 1'b0);
        do_txn(1'b1, 1'b0, 14'o17,   16'h0000, 1'b0);
        do_txn(1'b1, 1'b1, 14'o100,  16'h1357, 1'b1);
        do_txn(1'b1, 1'b0, 14'o100,  16'h0000, 1'b1);
        do_txn(1'b1, 1'b0, 14'o20,   16'h0000, 1'b0);
        do_txn(1'b1, 1'b0, 14'o1777, 16'h0000, 1'b0);
        do_txn(1'b1, 1'b0, 14'o2000, 16'h0000, 1'b0);
        do_txn(1'b0, 1'b1, 14'o0,    16'hFFFF, 1'b0);

        // A request held high is re-accepted the cycle after DONE: two ERS reads in 8 cycles.
        acks = 0;
        ADDRESS = 14'o300; RD_REQ = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK2);
            if (ACK) acks++;
        end
        RD_REQ = 1'b0;
        exp_rb = ref_mem[14'o300];
        check("held_req_acks", acks, 32'd2);
        @(negedge CLK2);
        check("held_req_rb", {16'b0, READ_BUS}, {16'b0, exp_rb});

        // Reset during a FIX read strobe.
        ADDRESS = 14'o4000; RD_REQ = 1'b1;
        @(posedge CLK2);
        #1;
        RD_REQ = 1'b0;
        @(negedge CLK2);
        check("pre_rst_oe", {31'b0, MEM_OE}, 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("rst_async_oe", {30'b0, MEM_OE, BUSY}, 32'd0);
        do_reset();
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK2);
            if (ACK) acks++;
        end
        check("rst_no_ack", acks, 32'd0);
        check("rst_idle_busy", {31'b0, BUSY}, 32'd0);
        check("rst_rb_cleared", {16'b0, READ_BUS}, 32'd0);

        // Parity: bad word raises a sticky alarm only when the feature is built in.
        mem[14'o200] = 17'h1_0001; ref_mem[14'o200] = 16'h0001; bad_par[14'o200] = 1'b1;
        do_txn(1'b1, 1'b0, 14'o200, 16'h0000, 1'b0);
        do_txn(1'b1, 1'b0, 14'o1234, 16'h0000, 1'b0);
        check("par_sticky", {31'b0, PAR_ALARM}, {31'b0, PAR_EN});
        do_reset();
        mem[14'o200] = 17'h0_0001; bad_par[14'o200] = 1'b0;
        do_txn(1'b1, 1'b0, 14'o200, 16'h0000, 1'b0);
        check("par_clean", {31'b0, PAR_ALARM}, 32'd0);

        // Randomized traffic across all classes.
        for (int n = 0; n < 60; n++) begin
            logic [13:0] a;
            int unsigned op, region;
            region = $urandom_range(0, 2);
            op     = $urandom_range(0, 2);
            if (region == 0)      a = 14'($urandom_range(0, 15));
            else if (region == 1) a = 14'($urandom_range(16, 1023));
            else                  a = 14'($urandom_range(1024, 16383));
            do_txn(op != 1, op != 0, a, 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
